// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: sequences one pipeline data-memory request at a time into a
// mem_system style port (Rd/Wr/Addr/DataIn -> DataOut/Done/CacheHit/err).
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : pipeline request (valid, store flag, byte address, store data)
//   halt              : end-of-program, forwarded as createdump only while idle
//   resp_valid        : one-cycle response strobe, resp_rdata holds load data
//   stall_out         : pipeline freeze while a request is accepted or in flight
//   err_out           : sticky error (misaligned, memory error, or timeout)
//   m_*               : memory-system side
//   access_count      : completed accesses (saturating)
//   hit_count         : completed accesses that hit (saturating)
module dmem_req_ctrl #(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        halt,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        stall_out,
  output logic        err_out,
  output logic [15:0] m_addr,
  output logic [15:0] m_datain,
  output logic        m_rd,
  output logic        m_wr,
  output logic        m_createdump,
  input  logic [15:0] m_dataout,
  input  logic        m_done,
  input  logic        m_cachehit,
  input  logic        m_err,
  output logic [15:0] access_count,
  output logic [15:0] hit_count
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               wr_q;
  logic [WAIT_W-1:0]  wait_q;

  logic latch_en;
  logic cap_load;
  logic cap_zero;
  logic set_err;
  logic done_acc;
  logic wait_clr;
  logic wait_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, datapath strobes and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    cap_load     = 1'b0;
    cap_zero     = 1'b0;
    set_err      = 1'b0;
    done_acc     = 1'b0;
    wait_clr     = 1'b0;
    wait_inc     = 1'b0;
    m_rd         = 1'b0;
    m_wr         = 1'b0;
    stall_out    = 1'b0;
    resp_valid   = 1'b0;
    m_createdump = 1'b0;

    case (state_q)
      S_IDLE: begin
        m_createdump = halt;
        if (req_valid) begin
          if (req_addr[0]) begin
            // Misaligned: no memory access, answer with zero data and flag error
            cap_zero = 1'b1;
            set_err  = 1'b1;
            state_d  = S_RESP;
          end else begin
            stall_out = 1'b1;
            latch_en  = 1'b1;
            wait_clr  = 1'b1;
            state_d   = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        stall_out = 1'b1;
        m_rd      = ~wr_q;
        m_wr      = wr_q;
        if (m_done || m_err) begin
          done_acc = m_done;
          cap_load = m_done & ~wr_q;
          set_err  = m_err;
          state_d  = S_RESP;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // This BUSY cycle makes TIMEOUT cycles without Done: abort
          set_err = 1'b1;
          state_d = S_RESP;
        end else begin
          wait_inc = 1'b1;
        end
      end

      S_RESP: begin
        // Drain cycle: late or repeated Done is ignored here
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request latch, response data, sticky error, wait and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr       <= '0;
      m_datain     <= '0;
      wr_q         <= 1'b0;
      resp_rdata   <= '0;
      err_out      <= 1'b0;
      wait_q       <= '0;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      if (latch_en) begin
        m_addr   <= req_addr;
        m_datain <= req_wdata;
        wr_q     <= req_wr;
      end

      if (cap_zero) begin
        resp_rdata <= '0;
      end else if (cap_load) begin
        resp_rdata <= m_dataout;
      end

      if (set_err) begin
        err_out <= 1'b1;
      end

      if (wait_clr) begin
        wait_q <= '0;
      end else if (wait_inc) begin
        wait_q <= wait_q + WAIT_W'(1);
      end

      if (done_acc && (access_count != CNT_MAX)) begin
        access_count <= access_count + 16'd1;
      end
      if (done_acc && m_cachehit && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Self-checking bench for dmem_req_ctrl: directed scenarios followed by random
// request streams, compared every cycle against a transaction-level model.
module tb_dmem_req_ctrl;

  localparam int unsigned TO = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        halt;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        stall_out, err_out;
  logic [15:0] m_addr, m_datain;
  logic        m_rd, m_wr, m_createdump;
  logic [15:0] m_dataout;
  logic        m_done, m_cachehit, m_err;
  logic [15:0] access_count, hit_count;

  dmem_req_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .halt(halt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall_out(stall_out), .err_out(err_out),
    .m_addr(m_addr), .m_datain(m_datain), .m_rd(m_rd), .m_wr(m_wr),
    .m_createdump(m_createdump),
    .m_dataout(m_dataout), .m_done(m_done), .m_cachehit(m_cachehit), .m_err(m_err),
    .access_count(access_count), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle
  logic        exp_rv, exp_stall, exp_err, exp_rd, exp_wr, exp_dump;
  logic [15:0] exp_rdata, exp_addr, exp_datain, exp_acc, exp_hit;

  // Architectural model state (as seen after the most recent edge)
  logic        mdl_err;
  logic [15:0] mdl_rdata, mdl_addr, mdl_data, mdl_acc, mdl_hit;

  logic halt_force = 1'b0;
  logic err_en     = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("resp_valid",   16'(resp_valid),   16'(exp_rv));
      chk("resp_rdata",   resp_rdata,        exp_rdata);
      chk("stall_out",    16'(stall_out),    16'(exp_stall));
      chk("err_out",      16'(err_out),      16'(exp_err));
      chk("m_rd",         16'(m_rd),         16'(exp_rd));
      chk("m_wr",         16'(m_wr),         16'(exp_wr));
      chk("m_addr",       m_addr,            exp_addr);
      chk("m_datain",     m_datain,          exp_datain);
      chk("m_createdump", 16'(m_createdump), 16'(exp_dump));
      chk("access_count", access_count,      exp_acc);
      chk("hit_count",    hit_count,         exp_hit);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    mdl_err = 1'b0; mdl_rdata = '0; mdl_addr = '0; mdl_data = '0;
    mdl_acc = '0;   mdl_hit = '0;
  endtask

  task automatic set_exp(input logic stall, input logic rd, input logic wr,
                         input logic rv, input logic dump);
    exp_stall = stall; exp_rd = rd; exp_wr = wr; exp_rv = rv; exp_dump = dump;
    exp_err = mdl_err; exp_rdata = mdl_rdata; exp_addr = mdl_addr;
    exp_datain = mdl_data; exp_acc = mdl_acc; exp_hit = mdl_hit;
  endtask

  task automatic noise();
    m_dataout  = 16'($urandom);
    m_cachehit = 1'($urandom);
    halt       = halt_force | ($urandom_range(0, 3) == 0);
    req_wr     = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
  endtask

  // Idle cycles: no request, stray Done/err pulses must be ignored
  task automatic idle(input int n, input logic force_done);
    repeat (n) begin
      cyc();
      noise();
      req_valid = 1'b0;
      m_done    = force_done | ($urandom_range(0, 2) == 0);
      m_err     = ($urandom_range(0, 3) == 0);
      set_exp(1'b0, 1'b0, 1'b0, 1'b0, halt);
    end
  endtask

  // One request. lat = BUSY cycle index on which Done arrives (>= TO means never).
  // rst_at >= 0 asserts reset on that BUSY cycle. hitmode 0 random, 1 hit, 2 miss.
  // Returns just after the RESP cycle (or the post-reset cycle) has been set up.
  task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int lat, input int rst_at, input logic rdone,
                        input int hitmode, input logic [15:0] dout);
    logic term;
    int   i;
    cyc();
    noise();
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    m_done = 1'($urandom); m_err = 1'($urandom);
    set_exp(~addr[0], 1'b0, 1'b0, 1'b0, halt);
    if (addr[0]) begin
      mdl_err = 1'b1;
      mdl_rdata = '0;
    end else begin
      mdl_addr = addr;
      mdl_data = wdata;
      i = 0;
      term = 1'b0;
      while (!term) begin
        cyc();
        noise();
        req_valid = 1'($urandom);
        m_done = (i == lat);
        m_err  = err_en && ($urandom_range(0, 39) == 0);
        if (i == lat) m_dataout = dout;
        if (hitmode == 1) m_cachehit = 1'b1;
        if (hitmode == 2) m_cachehit = 1'b0;
        set_exp(1'b1, ~wr, wr, 1'b0, 1'b0);
        if (i == rst_at) begin
          rst = 1'b1; m_done = 1'b1; m_cachehit = 1'b1;
          cyc();
          rst = 1'b0;
          noise();
          req_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
          mdl_reset();
          set_exp(1'b0, 1'b0, 1'b0, 1'b0, halt);
          return;
        end
        if (m_done) begin
          if (mdl_acc != 16'hFFFF) mdl_acc = mdl_acc + 16'd1;
          if (m_cachehit && mdl_hit != 16'hFFFF) mdl_hit = mdl_hit + 16'd1;
          if (!wr) mdl_rdata = m_dataout;
          term = 1'b1;
        end
        if (m_err) begin
          mdl_err = 1'b1;
          term = 1'b1;
        end
        if (!term && i == int'(TO) - 1) begin
          mdl_err = 1'b1;
          term = 1'b1;
        end
        i++;
      end
    end
    // Response / drain cycle
    cyc();
    noise();
    req_valid = 1'($urandom);
    m_done = rdone | 1'($urandom);
    m_err  = 1'($urandom);
    set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rand_txn();
    int lat;
    int sel;
    logic [15:0] a;
    sel = $urandom_range(0, 99);
    if (sel < 70)      lat = $urandom_range(0, 5);
    else if (sel < 95) lat = $urandom_range(6, 30);
    else               lat = 1000;
    a = 16'($urandom);
    if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
    do_txn(1'($urandom), a, 16'($urandom), lat, -1, 1'($urandom), 0, 16'($urandom));
    idle($urandom_range(0, 2), 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    halt = 1'b0; m_dataout = '0; m_done = 1'b0; m_cachehit = 1'b0; m_err = 1'b0;
    mdl_reset();
    cyc();
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Load hit at 0x0040, Done+hit on second BUSY cycle
    do_txn(1'b0, 16'h0040, 16'h1111, 1, -1, 1'b1, 1, 16'hBEEF);
    #1;
    chk("lit_hit_rv",    16'(resp_valid), 16'h0001);
    chk("lit_hit_rdata", resp_rdata,      16'hBEEF);
    chk("lit_hit_acc",   access_count,    16'd1);
    chk("lit_hit_hits",  hit_count,       16'd1);
    idle(1, 1'b1);
    #1;
    chk("lit_repeat_acc", access_count, 16'd1);
    chk("lit_repeat_rv",  16'(resp_valid), 16'h0000);

    // Store miss, 20 BUSY cycles
    do_txn(1'b1, 16'h1238, 16'h5A5A, 19, -1, 1'b0, 2, 16'h0000);
    #1;
    chk("lit_st_acc",   access_count, 16'd2);
    chk("lit_st_hits",  hit_count,    16'd1);
    chk("lit_st_rdata", resp_rdata,   16'hBEEF);
    chk("lit_st_err",   16'(err_out), 16'h0000);
    idle(1, 1'b0);

    // Misaligned
    do_txn(1'b0, 16'h0041, 16'h0000, 0, -1, 1'b0, 0, 16'h0000);
    #1;
    chk("lit_mis_rv",    16'(resp_valid), 16'h0001);
    chk("lit_mis_err",   16'(err_out),    16'h0001);
    chk("lit_mis_rdata", resp_rdata,      16'h0000);
    chk("lit_mis_acc",   access_count,    16'd2);
    idle(1, 1'b0);

    // Reset mid-access clears everything, then a timeout
    do_txn(1'b0, 16'h0100, 16'h0000, 50, 3, 1'b0, 0, 16'h0000);
    #1;
    chk("lit_rst_acc", access_count, 16'd0);
    chk("lit_rst_err", 16'(err_out), 16'h0000);
    chk("lit_rst_rd",  16'(m_rd),    16'h0000);
    do_txn(1'b0, 16'h0200, 16'h0000, 1000, -1, 1'b0, 0, 16'h0000);
    #1;
    chk("lit_to_err", 16'(err_out),    16'h0001);
    chk("lit_to_rv",  16'(resp_valid), 16'h0001);
    chk("lit_to_rd",  16'(m_rd),       16'h0000);

    // Halt held across an access: createdump only once back in IDLE
    halt_force = 1'b1;
    do_txn(1'b1, 16'h0300, 16'h7777, 4, -1, 1'b0, 0, 16'h0000);
    idle(1, 1'b0);
    #1;
    chk("lit_dump", 16'(m_createdump), 16'h0001);
    halt_force = 1'b0;

    // Random streams, with a mid-access reset between them to clear err_out
    err_en = 1'b1;
    repeat (150) rand_txn();
    do_txn(1'b1, 16'h0400, 16'h0000, 50, 2, 1'b0, 0, 16'h0000);
    err_en = 1'b0;
    repeat (60) rand_txn();
    err_en = 1'b1;
    repeat (100) rand_txn();

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
